// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD frame-buffer fetch path.
package lcd_pkg;

  localparam int unsigned H_ACTIVE = 800;
  localparam int unsigned V_ACTIVE = 480;

  // RGB565 pixel word: R in [15:11], G in [10:5], B in [4:0]
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WAIT_SPACE,
    ST_REQ,
    ST_DATA,
    ST_DRAIN
  } fetch_state_t;

endpackage

// File: rtl/lcd_line_fetcher.sv
// Frame-buffer read scheduler: walks the image line by line in bursts and
// writes the returned RGB565 words into the LCD pixel FIFO.
module lcd_line_fetcher #(
  parameter int unsigned H_ACTIVE   = lcd_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE   = lcd_pkg::V_ACTIVE,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 1024,
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned FB_BASE    = 0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              frame_start,
  input  logic [10:0]       fifo_level,
  output logic              FIFO_WE,
  output logic [15:0]       FIFO_WData,
  output logic              FIFO_CLR,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [4:0]        mem_len,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata,
  output logic              busy,
  output logic              frame_done
);
  import lcd_pkg::*;

  localparam int unsigned PIX_W  = 10;
  localparam int unsigned LINE_W = 9;
  localparam int unsigned LEN_W  = 5;
  localparam int unsigned LVL_W  = 12;

  fetch_state_t      r_state, w_state_nxt;
  logic [PIX_W-1:0]  r_pix, w_pix_nxt;
  logic [LINE_W-1:0] r_line, w_line_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [LEN_W-1:0]  r_len, w_len_nxt;
  logic [LEN_W-1:0]  r_word_cnt, w_word_cnt_nxt;
  rgb565_t           r_wdata, w_wdata_nxt;
  logic              r_we, w_we_nxt;
  logic              r_clr, r_req, r_busy;
  logic              r_done_pend, w_done_pend_nxt;
  logic              r_done;

  logic [PIX_W-1:0]  w_remain;
  logic [LEN_W-1:0]  w_burst;
  logic [LVL_W-1:0]  w_need;
  logic              w_space;
  logic              w_last;
  logic [PIX_W-1:0]  w_pix_adv;
  logic [LINE_W-1:0] w_line_adv;

  // Next burst length and FIFO room check (2-word margin for the write register)
  assign w_remain   = PIX_W'(H_ACTIVE) - r_pix;
  assign w_burst    = (w_remain < PIX_W'(BURST_LEN)) ? LEN_W'(w_remain) : LEN_W'(BURST_LEN);
  assign w_need     = LVL_W'(fifo_level) + LVL_W'(w_burst) + LVL_W'(2);
  assign w_space    = (w_need <= LVL_W'(FIFO_DEPTH));
  assign w_last     = mem_rvalid && (r_word_cnt == LEN_W'(1));
  assign w_pix_adv  = r_pix + PIX_W'(r_len);
  assign w_line_adv = r_line + LINE_W'(1);

  always_comb begin
    w_state_nxt     = r_state;
    w_pix_nxt       = r_pix;
    w_line_nxt      = r_line;
    w_addr_nxt      = r_addr;
    w_len_nxt       = r_len;
    w_word_cnt_nxt  = r_word_cnt;
    w_wdata_nxt     = r_wdata;
    w_we_nxt        = 1'b0;
    w_done_pend_nxt = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (frame_start) w_state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        w_state_nxt = ST_WAIT_SPACE;
      end
      ST_WAIT_SPACE: begin
        if (frame_start) begin
          w_state_nxt = ST_CLEAR;
        end else if (w_space) begin
          w_state_nxt = ST_REQ;
          w_len_nxt   = w_burst;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          w_word_cnt_nxt = r_len;
          w_state_nxt    = frame_start ? ST_DRAIN : ST_DATA;
        end else if (frame_start) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DATA: begin
        if (mem_rvalid) begin
          w_word_cnt_nxt = r_word_cnt - LEN_W'(1);
          w_we_nxt       = !frame_start;
          w_wdata_nxt    = rgb565_t'(mem_rdata);
        end
        if (frame_start) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_last) begin
          w_addr_nxt  = r_addr + ADDR_W'(r_len);
          w_state_nxt = ST_WAIT_SPACE;
          if (w_pix_adv == PIX_W'(H_ACTIVE)) begin
            w_pix_nxt  = '0;
            w_line_nxt = w_line_adv;
            if (w_line_adv == LINE_W'(V_ACTIVE)) begin
              w_state_nxt     = ST_IDLE;
              w_done_pend_nxt = 1'b1;
            end
          end else begin
            w_pix_nxt = w_pix_adv;
          end
        end
      end
      ST_DRAIN: begin
        // Consume the rest of an accepted burst without writing it
        if (mem_rvalid && (r_word_cnt != '0)) w_word_cnt_nxt = r_word_cnt - LEN_W'(1);
        if ((r_word_cnt == '0) || w_last) w_state_nxt = ST_CLEAR;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_state_nxt == ST_CLEAR) begin
      w_pix_nxt  = '0;
      w_line_nxt = '0;
      w_addr_nxt = ADDR_W'(FB_BASE);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= ST_IDLE;
      r_pix       <= '0;
      r_line      <= '0;
      r_addr      <= ADDR_W'(FB_BASE);
      r_len       <= '0;
      r_word_cnt  <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_clr       <= 1'b0;
      r_req       <= 1'b0;
      r_busy      <= 1'b0;
      r_done_pend <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pix       <= w_pix_nxt;
      r_line      <= w_line_nxt;
      r_addr      <= w_addr_nxt;
      r_len       <= w_len_nxt;
      r_word_cnt  <= w_word_cnt_nxt;
      r_wdata     <= w_wdata_nxt;
      r_we        <= w_we_nxt;
      r_clr       <= (w_state_nxt == ST_CLEAR);
      r_req       <= (w_state_nxt == ST_REQ);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_done_pend <= w_done_pend_nxt;
      r_done      <= r_done_pend;
    end
  end

  assign FIFO_WE    = r_we;
  assign FIFO_WData = r_wdata;
  assign FIFO_CLR   = r_clr;
  assign mem_req    = r_req;
  assign mem_addr   = r_addr;
  assign mem_len    = r_len;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: tb/tb_lcd_line_fetcher.sv
// Self-checking bench for lcd_line_fetcher: random memory/FIFO models against
// an arithmetic reference of the burst schedule and pixel ramp.
module tb_lcd_line_fetcher;

  localparam int          H_ACT  = 808;
  localparam int          V_ACT  = 3;
  localparam int          BLEN   = 16;
  localparam int          DEPTH  = 1024;
  localparam logic [23:0] BASE   = 24'hFFFC00;
  localparam int          NWORDS = H_ACT * V_ACT;
  localparam int          PER_LN = (H_ACT + BLEN - 1) / BLEN;
  localparam int          NREQ   = V_ACT * PER_LN;

  logic        CLK;
  logic        nRST;
  logic        frame_start;
  logic [10:0] fifo_level;
  logic        FIFO_WE;
  logic [15:0] FIFO_WData;
  logic        FIFO_CLR;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic [4:0]  mem_len;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        frame_done;

  int n_tests;
  int n_fail;

  // Memory and FIFO model controls (written only by the main sequence)
  logic mem_en;
  int   ack_dly_max;
  int   gap_pct;
  int   word_limit;
  logic use_fifo_model;
  int   fixed_level;
  int   drain_pct;

  // Model state (written only by the model processes)
  int          words_given;
  int          rd_left;
  logic [23:0] rd_addr;
  int          dly;
  logic        req_seen;
  int          occ;
  int          max_occ;

  lcd_line_fetcher #(
    .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .BURST_LEN(BLEN),
    .FIFO_DEPTH(DEPTH), .ADDR_W(24), .FB_BASE(32'h00FFFC00)
  ) dut (
    .CLK(CLK), .nRST(nRST), .frame_start(frame_start), .fifo_level(fifo_level),
    .FIFO_WE(FIFO_WE), .FIFO_WData(FIFO_WData), .FIFO_CLR(FIFO_CLR),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_len(mem_len), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy), .frame_done(frame_done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference: expected address/length of the idx-th request of a frame
  function automatic void req_model(input int idx, output logic [23:0] a, output int l);
    int ln;
    int p;
    ln = idx / PER_LN;
    p  = (idx % PER_LN) * BLEN;
    l  = (H_ACT - p < BLEN) ? (H_ACT - p) : BLEN;
    a  = BASE + 24'(ln * H_ACT + p);
  endfunction

  // Reference: k-th pixel of the frame is the low half of its word address
  function automatic logic [15:0] exp_word(input int k);
    logic [23:0] a;
    a = BASE + 24'(k);
    return a[15:0];
  endfunction

  // Memory: acks after a random delay, returns address-ramp data with random gaps
  initial begin : mem_model
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    words_given = 0; rd_left = 0; rd_addr = '0; dly = 0; req_seen = 1'b0;
    forever begin
      @(negedge CLK);
      mem_ack = 1'b0;
      mem_rvalid = 1'b0;
      if (nRST !== 1'b1 || !mem_en) begin
        rd_left = 0;
        req_seen = 1'b0;
      end else begin
        if (rd_left > 0) begin
          if (words_given < word_limit && int'($urandom_range(99, 0)) >= gap_pct) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rd_addr[15:0];
            rd_addr    = rd_addr + 24'd1;
            rd_left--;
            words_given++;
          end
        end else if (mem_req === 1'b1) begin
          if (!req_seen) begin
            req_seen = 1'b1;
            dly = int'($urandom_range(ack_dly_max, 0));
          end
          if (dly == 0) begin
            mem_ack  = 1'b1;
            req_seen = 1'b0;
            rd_addr  = mem_addr;
            rd_left  = int'(mem_len);
          end else begin
            dly--;
          end
        end else begin
          req_seen = 1'b0;
        end
      end
    end
  end

  // Pixel FIFO occupancy: counts writes, drains randomly, flushes on FIFO_CLR
  initial begin : fifo_model
    occ = 0; max_occ = 0; fifo_level = '0;
    forever begin
      @(negedge CLK);
      if (!use_fifo_model) begin
        occ = 0;
        max_occ = 0;
      end else begin
        if (FIFO_CLR === 1'b1) occ = 0;
        if (FIFO_WE === 1'b1) occ++;
        if (occ > max_occ) max_occ = occ;
        if (occ > 0 && int'($urandom_range(99, 0)) < drain_pct) occ--;
      end
      fifo_level = use_fifo_model ? 11'(occ) : 11'(fixed_level);
    end
  end

  task automatic do_reset();
    frame_start = 1'b0;
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    @(negedge CLK);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    n_tests++;
    if ({FIFO_WE, FIFO_CLR, mem_req, busy, frame_done} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000", {FIFO_WE, FIFO_CLR, mem_req, busy, frame_done});
    end
    n_tests++;
    if (FIFO_WData !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_wdata: got %h want 0000", FIFO_WData);
    end
    n_tests++;
    if (mem_addr !== BASE) begin
      n_fail++;
      $display("FAIL reset_addr: got %h want %h", mem_addr, BASE);
    end
    n_tests++;
    if (mem_len !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_len: got %0d want 0", mem_len);
    end
    nRST = 1'b1;
    repeat (5) @(negedge CLK);
    n_tests++;
    if ({mem_req, busy, FIFO_CLR} !== 3'b0) begin
      n_fail++;
      $display("FAIL idle_quiet: got %b want 000", {mem_req, busy, FIFO_CLR});
    end
  endtask

  task automatic test_full_frame();
    int          we_cnt, req_cnt, done_cnt, last_we, done_at, n16, n8, el;
    logic        prev_req;
    logic [23:0] ea, last_addr, line1_addr;
    we_cnt = 0; req_cnt = 0; done_cnt = 0; last_we = -10; done_at = -1; n16 = 0; n8 = 0;
    prev_req = 1'b0; last_addr = '0; line1_addr = '0;
    do_reset();
    ack_dly_max = 0; gap_pct = 0; fixed_level = 0; use_fifo_model = 1'b0;
    pulse_start();
    n_tests++;
    if (FIFO_CLR !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_clr: got clr=%b req=%b busy=%b want 1 0 1", FIFO_CLR, mem_req, busy);
    end
    @(negedge CLK);
    n_tests++;
    if (FIFO_CLR !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL start_gap: got clr=%b req=%b want 0 0", FIFO_CLR, mem_req);
    end
    for (int cyc = 0; cyc < 8000; cyc++) begin
      @(negedge CLK);
      if (cyc == 0) begin
        n_tests++;
        if (mem_req !== 1'b1) begin
          n_fail++;
          $display("FAIL first_req_latency: got %b want 1", mem_req);
        end
      end
      if (mem_req === 1'b1 && !prev_req) begin
        req_model(req_cnt, ea, el);
        n_tests++;
        if (mem_addr !== ea || int'(mem_len) != el) begin
          n_fail++;
          $display("FAIL req_%0d: got %h/%0d want %h/%0d", req_cnt, mem_addr, mem_len, ea, el);
        end
        if (mem_len == 5'd16) n16++;
        if (mem_len == 5'd8) n8++;
        if (req_cnt == PER_LN) line1_addr = mem_addr;
        last_addr = mem_addr;
        req_cnt++;
      end
      prev_req = mem_req;
      if (FIFO_WE === 1'b1) begin
        n_tests++;
        if (FIFO_WData !== exp_word(we_cnt)) begin
          n_fail++;
          $display("FAIL word_%0d: got %h want %h", we_cnt, FIFO_WData, exp_word(we_cnt));
        end
        we_cnt++;
        last_we = cyc;
      end
      if (frame_done === 1'b1) begin
        done_cnt++;
        done_at = cyc;
      end
      if (done_at >= 0 && cyc >= done_at + 4) break;
    end
    n_tests++;
    if (done_at < 0) begin
      n_fail++;
      $display("FAIL frame_timeout: got no frame_done want one");
    end
    n_tests++;
    if (we_cnt != NWORDS) begin
      n_fail++;
      $display("FAIL we_count: got %0d want %0d", we_cnt, NWORDS);
    end
    n_tests++;
    if (req_cnt != NREQ) begin
      n_fail++;
      $display("FAIL req_count: got %0d want %0d", req_cnt, NREQ);
    end
    n_tests++;
    if (n16 != V_ACT * 50 || n8 != V_ACT) begin
      n_fail++;
      $display("FAIL len_mix: got %0d/%0d want %0d/%0d", n16, n8, V_ACT * 50, V_ACT);
    end
    n_tests++;
    if (line1_addr !== 24'hFFFF28) begin
      n_fail++;
      $display("FAIL line1_addr: got %h want FFFF28", line1_addr);
    end
    n_tests++;
    if (last_addr !== 24'h000570) begin
      n_fail++;
      $display("FAIL last_addr: got %h want 000570", last_addr);
    end
    n_tests++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL done_count: got %0d want 1", done_cnt);
    end
    n_tests++;
    if (done_at != last_we + 1) begin
      n_fail++;
      $display("FAIL done_timing: got %0d want %0d", done_at, last_we + 1);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_end: got %b want 0", busy);
    end
  endtask

  task automatic test_space();
    logic seen;
    int   lat;
    do_reset();
    fixed_level = 1010;
    pulse_start();
    seen = 1'b0;
    repeat (30) begin
      @(negedge CLK);
      if (mem_req === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL level_1010: got req=%b busy=%b want 0 1", seen, busy);
    end
    pulse_start();
    n_tests++;
    if (FIFO_CLR !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_wait: got clr=%b want 1", FIFO_CLR);
    end
    @(posedge CLK);
    #1 fixed_level = 1007;
    seen = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      if (mem_req === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL level_1007: got req=%b want 0", seen);
    end
    @(posedge CLK);
    #1 fixed_level = 1006;
    lat = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      if (mem_req === 1'b1 && lat < 0) lat = i;
    end
    n_tests++;
    if (lat < 1 || lat > 2) begin
      n_fail++;
      $display("FAIL level_1006: got latency %0d want 1..2", lat);
    end
    fixed_level = 0;
  endtask

  task automatic test_abort();
    int   we_cnt, we_after, clr_cnt, left_at_clr;
    logic got_req, prev_req, req_ok;
    we_cnt = 0; we_after = 0; clr_cnt = 0; left_at_clr = -1;
    got_req = 1'b0; prev_req = 1'b0; req_ok = 1'b0;
    do_reset();
    fixed_level = 0; ack_dly_max = 0; gap_pct = 0;
    word_limit = words_given + 10;
    pulse_start();
    for (int i = 0; i < 200 && we_cnt < 10; i++) begin
      @(negedge CLK);
      if (FIFO_WE === 1'b1) we_cnt++;
    end
    repeat (3) begin
      @(negedge CLK);
      if (FIFO_WE === 1'b1) we_cnt++;
    end
    n_tests++;
    if (we_cnt != 10) begin
      n_fail++;
      $display("FAIL abort_pre: got %0d words want 10", we_cnt);
    end
    frame_start = 1'b1;
    word_limit = 1 << 30;
    @(negedge CLK);
    frame_start = 1'b0;
    for (int i = 0; i < 100 && !got_req; i++) begin
      @(negedge CLK);
      if (FIFO_WE === 1'b1) we_after++;
      if (FIFO_CLR === 1'b1) begin
        clr_cnt++;
        left_at_clr = rd_left;
      end
      if (mem_req === 1'b1 && !prev_req && clr_cnt > 0) begin
        got_req = 1'b1;
        req_ok = (mem_addr === BASE) && (mem_len === 5'd16);
      end
      prev_req = mem_req;
    end
    n_tests++;
    if (we_after != 0) begin
      n_fail++;
      $display("FAIL abort_we: got %0d writes want 0", we_after);
    end
    n_tests++;
    if (clr_cnt != 1 || left_at_clr != 0) begin
      n_fail++;
      $display("FAIL abort_clr: got %0d pulses, %0d words left want 1, 0", clr_cnt, left_at_clr);
    end
    n_tests++;
    if (!got_req || !req_ok) begin
      n_fail++;
      $display("FAIL abort_restart: got req=%b addr=%h want 1 %h", got_req, mem_addr, BASE);
    end
  endtask

  task automatic test_reset_req();
    logic seen, act;
    seen = 1'b0; act = 1'b0;
    mem_en = 1'b0;
    do_reset();
    pulse_start();
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK);
      if (mem_req === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rst_setup: got no mem_req want 1");
    end
    nRST = 1'b0;
    #1;
    n_tests++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: got req=%b busy=%b want 0 0", mem_req, busy);
    end
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      if (mem_req === 1'b1 || busy === 1'b1 || FIFO_CLR === 1'b1 || FIFO_WE === 1'b1) act = 1'b1;
    end
    n_tests++;
    if (act !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_quiet: got activity=%b want 0", act);
    end
    mem_en = 1'b1;
  endtask

  task automatic test_random();
    int          we_cnt, req_cnt, el;
    logic        prev_req, done;
    logic [23:0] ea;
    we_cnt = 0; req_cnt = 0; prev_req = 1'b0; done = 1'b0;
    do_reset();
    use_fifo_model = 1'b1; drain_pct = 15; ack_dly_max = 5; gap_pct = 30;
    pulse_start();
    for (int cyc = 0; cyc < 40000 && !done; cyc++) begin
      @(negedge CLK);
      if (mem_req === 1'b1 && !prev_req) begin
        req_model(req_cnt, ea, el);
        n_tests++;
        if (mem_addr !== ea || int'(mem_len) != el) begin
          n_fail++;
          $display("FAIL rnd_req_%0d: got %h/%0d want %h/%0d", req_cnt, mem_addr, mem_len, ea, el);
        end
        req_cnt++;
      end
      prev_req = mem_req;
      if (FIFO_WE === 1'b1) begin
        n_tests++;
        if (FIFO_WData !== exp_word(we_cnt)) begin
          n_fail++;
          $display("FAIL rnd_word_%0d: got %h want %h", we_cnt, FIFO_WData, exp_word(we_cnt));
        end
        we_cnt++;
      end
      if (frame_done === 1'b1) done = 1'b1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL rnd_timeout: got no frame_done want one");
    end
    n_tests++;
    if (we_cnt != NWORDS) begin
      n_fail++;
      $display("FAIL rnd_we_count: got %0d want %0d", we_cnt, NWORDS);
    end
    n_tests++;
    if (req_cnt != NREQ) begin
      n_fail++;
      $display("FAIL rnd_req_count: got %0d want %0d", req_cnt, NREQ);
    end
    n_tests++;
    if (max_occ > DEPTH - 2) begin
      n_fail++;
      $display("FAIL rnd_overflow: got max %0d want <= %0d", max_occ, DEPTH - 2);
    end
    use_fifo_model = 1'b0; ack_dly_max = 0; gap_pct = 0; drain_pct = 0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    nRST = 1'b0; frame_start = 1'b0;
    mem_en = 1'b1; ack_dly_max = 0; gap_pct = 0; word_limit = 1 << 30;
    use_fifo_model = 1'b0; fixed_level = 0; drain_pct = 0;
    test_reset();
    test_full_frame();
    test_space();
    test_abort();
    test_reset_req();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
